// File: rtl/cpu_ad48_irq_ctrl.sv
// cpu_ad48_irq_ctrl: prioritised interrupt controller for the cpu_ad48 irq input.
// Edge and level sources feed a PENDING register. ENABLE, MODE and PRIO registers
// select which sources may request and at which priority. A CLAIM/COMPLETE pair
// tracks in-service sources.
// Optional build macro CPU_AD48_IRQ_SYNC_EN puts a two-flop synchronizer on every src bit.
module cpu_ad48_irq_ctrl #(
  parameter int unsigned SRC_LINES = 8,
  parameter int unsigned IRQ_LINES = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [SRC_LINES-1:0] src,
  input  logic                 cfg_valid,
  input  logic                 cfg_write,
  input  logic [3:0]           cfg_addr,
  input  logic [47:0]          cfg_wdata,
  output logic                 cfg_ready,
  output logic                 cfg_rvalid,
  output logic [47:0]          cfg_rdata,
  output logic [IRQ_LINES-1:0] irq
);

  localparam int unsigned DW   = 48;
  localparam int unsigned PW   = 2 * SRC_LINES;
  localparam logic [1:0]  PMAX = 2'(IRQ_LINES - 1);

  localparam logic [3:0] A_PENDING  = 4'd0;
  localparam logic [3:0] A_ENABLE   = 4'd1;
  localparam logic [3:0] A_MODE     = 4'd2;
  localparam logic [3:0] A_PRIO     = 4'd3;
  localparam logic [3:0] A_CLAIM    = 4'd4;
  localparam logic [3:0] A_COMPLETE = 4'd5;

  logic                 r_ready;
  logic                 r_rvalid;
  logic [DW-1:0]        r_rdata;
  logic [IRQ_LINES-1:0] r_irq;
  logic [SRC_LINES-1:0] r_pending;
  logic [SRC_LINES-1:0] r_enable;
  logic [SRC_LINES-1:0] r_mode;
  logic [PW-1:0]        r_prio;
  logic [SRC_LINES-1:0] r_in_service;
  logic [SRC_LINES-1:0] r_hist;

  logic [SRC_LINES-1:0] w_samp;
  logic [SRC_LINES-1:0] w_rise;
  logic                 w_rd;
  logic                 w_wr;
  logic [SRC_LINES-1:0] w_wdata_s;
  logic [SRC_LINES-1:0] w_elig;
  logic [SRC_LINES-1:0] w_pend_vis;
  logic                 w_found;
  logic [3:0]           w_claim_idx;
  logic [1:0]           w_best;
  logic [4:0]           w_claim_id;
  logic [IRQ_LINES-1:0] w_irq_nxt;
  logic [SRC_LINES-1:0] w_claim_mask;
  logic [SRC_LINES-1:0] w_cpl_mask;
  logic [SRC_LINES-1:0] w_w1c;
  logic [SRC_LINES-1:0] w_mode_chg;
  logic [SRC_LINES-1:0] w_pend_nxt;
  logic [DW-1:0]        w_rdmux;
  logic                 w_unused;

`ifdef CPU_AD48_IRQ_SYNC_EN
  logic [SRC_LINES-1:0] r_sync1;
  logic [SRC_LINES-1:0] r_sync2;

  // Two-flop synchronizer for asynchronous sources
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_samp = r_sync2;
`else
  assign w_samp = src;
`endif

  assign w_rise     = w_samp & ~r_hist;
  assign w_rd       = cfg_valid & r_ready & ~cfg_write;
  assign w_wr       = cfg_valid & r_ready & cfg_write;
  assign w_wdata_s  = cfg_wdata[SRC_LINES-1:0];
  assign w_unused   = ^cfg_wdata;

  // Level pending is hidden while the source is in service
  assign w_pend_vis = r_pending & ~(~r_mode & r_in_service);
  assign w_elig     = r_pending & r_enable & ~r_in_service;

  // Effective priority, claim winner (highest priority, lowest index) and next irq lines
  always_comb begin
    logic [1:0] w_eff;
    w_found     = 1'b0;
    w_claim_idx = '0;
    w_best      = '0;
    w_irq_nxt   = '0;
    for (int unsigned i = 0; i < SRC_LINES; i++) begin
      w_eff = (r_prio[2*i +: 2] > PMAX) ? PMAX : r_prio[2*i +: 2];
      if (w_elig[i] && (!w_found || (w_eff > w_best))) begin
        w_found     = 1'b1;
        w_claim_idx = 4'(i);
        w_best      = w_eff;
      end
      for (int unsigned k = 0; k < IRQ_LINES; k++) begin
        if (w_elig[i] && (w_eff == 2'(k))) w_irq_nxt[k] = 1'b1;
      end
    end
  end

  assign w_claim_id   = w_found ? ({1'b0, w_claim_idx} + 5'd1) : 5'd0;
  assign w_claim_mask = (w_rd && (cfg_addr == A_CLAIM) && w_found)
                        ? (SRC_LINES'(1) << w_claim_idx) : '0;
  assign w_cpl_mask   = (w_wr && (cfg_addr == A_COMPLETE) && (32'(cfg_wdata[3:0]) < SRC_LINES))
                        ? (SRC_LINES'(1) << cfg_wdata[3:0]) : '0;
  assign w_w1c        = (w_wr && (cfg_addr == A_PENDING)) ? (w_wdata_s & r_mode) : '0;
  assign w_mode_chg   = (w_wr && (cfg_addr == A_MODE)) ? (w_wdata_s ^ r_mode) : '0;

  // Edge: a new rise beats a W1C/claim in the same cycle; level: follow the sample
  assign w_pend_nxt = ((r_mode & ((r_pending & ~(w_w1c | w_claim_mask)) | w_rise)) |
                       (~r_mode & w_samp)) & ~w_mode_chg;

  // Register read multiplexer
  always_comb begin
    w_rdmux = '0;
    case (cfg_addr)
      A_PENDING: w_rdmux = DW'(w_pend_vis);
      A_ENABLE:  w_rdmux = DW'(r_enable);
      A_MODE:    w_rdmux = DW'(r_mode);
      A_PRIO:    w_rdmux = DW'(r_prio);
      A_CLAIM:   w_rdmux = DW'(w_claim_id);
      default:   w_rdmux = '0;
    endcase
  end

  // Controller state, configuration registers and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready      <= 1'b0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_irq        <= '0;
      r_pending    <= '0;
      r_enable     <= '0;
      r_mode       <= '0;
      r_prio       <= '0;
      r_in_service <= '0;
      r_hist       <= '0;
    end else begin
      r_ready      <= 1'b1;
      r_hist       <= w_samp;
      r_pending    <= w_pend_nxt;
      r_in_service <= (r_in_service | w_claim_mask) & ~w_cpl_mask;
      r_rvalid     <= w_rd;
      r_rdata      <= w_rd ? w_rdmux : '0;
      r_irq        <= w_irq_nxt;
      if (w_wr && (cfg_addr == A_ENABLE)) r_enable <= w_wdata_s;
      if (w_wr && (cfg_addr == A_MODE))   r_mode   <= w_wdata_s;
      if (w_wr && (cfg_addr == A_PRIO))   r_prio   <= cfg_wdata[PW-1:0];
    end
  end

  assign cfg_ready  = r_ready;
  assign cfg_rvalid = r_rvalid;
  assign cfg_rdata  = r_rdata;
  assign irq        = r_irq;

endmodule

// File: tb/tb_cpu_ad48_irq_ctrl.sv
// tb_cpu_ad48_irq_ctrl: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the controller.
module tb_cpu_ad48_irq_ctrl;

  localparam int S = 8;
  localparam int L = 4;
`ifdef CPU_AD48_IRQ_SYNC_EN
  localparam int LAT = 4;
  localparam int SD  = 2;
`else
  localparam int LAT = 2;
  localparam int SD  = 0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [S-1:0] src;
  logic         cfg_valid, cfg_write;
  logic [3:0]   cfg_addr;
  logic [47:0]  cfg_wdata;
  logic         cfg_ready, cfg_rvalid;
  logic [47:0]  cfg_rdata;
  logic [L-1:0] irq;

  int n_vec = 0;
  int n_err = 0;

  cpu_ad48_irq_ctrl #(.SRC_LINES(S), .IRQ_LINES(L)) dut (
    .clk(clk), .resetn(resetn), .src(src),
    .cfg_valid(cfg_valid), .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [S-1:0]   m_pend = '0, m_en = '0, m_mode = '0, m_insvc = '0;
  logic [2*S-1:0] m_prio = '0;
  logic [S-1:0]   m_past0 = '0, m_past1 = '0, m_past2 = '0;
  logic           m_ready = 1'b0, m_rvalid = 1'b0;
  logic [47:0]    m_rdata = '0;
  logic [L-1:0]   m_irq = '0;

  function automatic int eff(input int i);
    int p;
    p = int'(m_prio[2*i +: 2]);
    return (p > L - 1) ? L - 1 : p;
  endfunction

  always @(posedge clk or negedge resetn) begin
    logic [S-1:0] samp, prev, elig, pvis;
    logic [L-1:0] irq_n;
    logic         rdq, wrq;
    logic [47:0]  val;
    int           cid;
    if (!resetn) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_insvc = '0; m_prio = '0;
      m_past0 = '0; m_past1 = '0; m_past2 = '0;
      m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_irq = '0;
    end else begin
`ifdef CPU_AD48_IRQ_SYNC_EN
      samp = m_past1; prev = m_past2;
`else
      samp = src;     prev = m_past0;
`endif
      pvis = m_pend & ~(~m_mode & m_insvc);
      elig = m_pend & m_en & ~m_insvc;
      irq_n = '0;
      for (int i = 0; i < S; i++) if (elig[i]) irq_n[eff(i)] = 1'b1;
      cid = 0;
      for (int p = L - 1; p >= 0; p--)
        for (int i = 0; i < S; i++)
          if (cid == 0 && elig[i] && eff(i) == p) cid = i + 1;
      rdq = cfg_valid && m_ready && !cfg_write;
      wrq = cfg_valid && m_ready && cfg_write;
      case (cfg_addr)
        4'd0: val = 48'(pvis);
        4'd1: val = 48'(m_en);
        4'd2: val = 48'(m_mode);
        4'd3: val = 48'(m_prio);
        4'd4: val = 48'(cid);
        default: val = '0;
      endcase
      for (int i = 0; i < S; i++) begin
        if (m_mode[i]) begin
          if ((wrq && cfg_addr == 4'd0 && cfg_wdata[i]) || (rdq && cfg_addr == 4'd4 && cid == i + 1))
            m_pend[i] = 1'b0;
          if (samp[i] && !prev[i]) m_pend[i] = 1'b1;
        end else begin
          m_pend[i] = samp[i];
        end
        if (wrq && cfg_addr == 4'd2 && cfg_wdata[i] != m_mode[i]) m_pend[i] = 1'b0;
      end
      if (rdq && cfg_addr == 4'd4 && cid != 0) m_insvc[cid-1] = 1'b1;
      if (wrq && cfg_addr == 4'd5 && int'(cfg_wdata[3:0]) < S) m_insvc[cfg_wdata[3:0]] = 1'b0;
      if (wrq && cfg_addr == 4'd1) m_en   = cfg_wdata[S-1:0];
      if (wrq && cfg_addr == 4'd2) m_mode = cfg_wdata[S-1:0];
      if (wrq && cfg_addr == 4'd3) m_prio = cfg_wdata[2*S-1:0];
      m_rvalid = rdq;
      m_rdata  = rdq ? val : '0;
      m_irq    = irq_n;
      m_ready  = 1'b1;
      m_past2 = m_past1; m_past1 = m_past0; m_past0 = src;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("ready",  48'(cfg_ready),  48'(m_ready));
    check("rvalid", 48'(cfg_rvalid), 48'(m_rvalid));
    check("rdata",  cfg_rdata,       m_rdata);
    check("irq",    48'(irq),        48'(m_irq));
  end

  // ---------------- stimulus helpers (called in the slot just after posedge) ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [47:0] d);
    cfg_valid = 1'b1; cfg_write = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc(1);
    cfg_valid = 1'b0; cfg_write = 1'b0;
  endtask

  task automatic rdchk(input string nm, input logic [3:0] a, input logic [47:0] exp);
    cfg_valid = 1'b1; cfg_write = 1'b0; cfg_addr = a;
    cyc(1);
    cfg_valid = 1'b0;
    check(nm, cfg_rdata, exp);
  endtask

  initial begin
    int b;
    int a;
    resetn = 1'b1; src = '0; cfg_valid = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_ready",  48'(cfg_ready), 48'd0);
    check("rst_rvalid", 48'(cfg_rvalid), 48'd0);
    check("rst_rdata",  cfg_rdata, 48'd0);
    check("rst_irq",    48'(irq), 48'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    check("ready_before_edge", 48'(cfg_ready), 48'd0);
    cyc(1);
    check("ready_after_edge", 48'(cfg_ready), 48'd1);

    // Single edge source, priority 0
    wr(4'd1, 48'h01); wr(4'd2, 48'h01); wr(4'd3, 48'h0);
    src = 8'h01;
    cyc(LAT - 1);
    check("s0_irq_early", 48'(irq), 48'h0);
    cyc(1);
    check("s0_irq", 48'(irq), 48'h1);
    src = 8'h00;
    rdchk("s0_claim", 4'd4, 48'd1);
    cyc(1);
    check("s0_irq_after_claim", 48'(irq), 48'h0);
    rdchk("s0_pending", 4'd0, 48'h0);

    // Two sources at different priorities
    wr(4'd5, 48'd0);
    wr(4'd1, 48'h24); wr(4'd2, 48'h24); wr(4'd3, 48'hC10);
    src = 8'h24;
    cyc(LAT);
    check("dual_irq", 48'(irq), 48'hA);
    rdchk("claim_first",  4'd4, 48'd6);
    rdchk("claim_second", 4'd4, 48'd3);
    rdchk("claim_none",   4'd4, 48'd0);
    src = 8'h00;
    wr(4'd5, 48'd5); wr(4'd5, 48'd2);

    // Level source, claim and complete
    wr(4'd2, 48'h00); wr(4'd1, 48'h08); wr(4'd3, 48'h0);
    src = 8'h08;
    cyc(LAT);
    check("lvl_irq", 48'(irq), 48'h1);
    rdchk("lvl_claim", 4'd4, 48'd4);
    cyc(1);
    check("lvl_irq_dropped", 48'(irq), 48'h0);
    wr(4'd5, 48'd9);
    cyc(2);
    check("lvl_cpl_bad_id", 48'(irq), 48'h0);
    wr(4'd5, 48'd3);
    check("lvl_cpl_same_edge", 48'(irq), 48'h0);
    cyc(1);
    check("lvl_reassert", 48'(irq), 48'h1);

    // New edge coinciding with W1C: set wins
    src = 8'h00;
    wr(4'd2, 48'h02); wr(4'd1, 48'h02);
    cyc(LAT);
    src = 8'h02; cyc(LAT);
    src = 8'h00; cyc(LAT);
    rdchk("edge_pending", 4'd0, 48'h02);
    src = 8'h02;
    cyc(SD);
    wr(4'd0, 48'h02);
    rdchk("w1c_vs_edge", 4'd0, 48'h02);
    wr(4'd0, 48'h02);
    rdchk("w1c_clears", 4'd0, 48'h00);

    // Bits above SRC_LINES and unmapped addresses
    wr(4'd1, 48'hFFFF_FFFF_FFFF);
    rdchk("enable_width", 4'd1, 48'hFF);
    rdchk("unmapped", 4'd7, 48'h0);
    wr(4'd1, 48'h02);

    // Reset mid-operation with pending and in_service set
    src = 8'h00; cyc(LAT);
    src = 8'h02; cyc(LAT);
    check("pre_rst_irq", 48'(irq), 48'h1);
    rdchk("pre_rst_claim", 4'd4, 48'd2);
    src = 8'h00; cyc(LAT);
    src = 8'h02; cyc(LAT);
    rdchk("pre_rst_pending", 4'd0, 48'h02);
    src = 8'h00;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_irq",    48'(irq), 48'h0);
    check("mid_rst_rvalid", 48'(cfg_rvalid), 48'h0);
    check("mid_rst_ready",  48'(cfg_ready), 48'h0);
    #4 resetn = 1'b1;
    cyc(2);
    for (int r = 0; r < 5; r++) rdchk("post_rst_reg", 4'(r), 48'h0);
    check("post_rst_irq", 48'(irq), 48'h0);
    wr(4'd1, 48'h02); wr(4'd2, 48'h02);
    src = 8'h02;
    cyc(LAT);
    rdchk("no_stale_in_service", 4'd4, 48'd2);
    src = 8'h00;

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(3) == 0) begin
        b = int'($urandom_range(S - 1));
        src[b] = ~src[b];
      end
      cfg_valid = 1'($urandom_range(1));
      cfg_write = 1'($urandom_range(1));
      a = ($urandom_range(3) != 0) ? int'($urandom_range(5)) : int'($urandom_range(15));
      if (a == 2 && $urandom_range(3) != 0) cfg_write = 1'b0;
      cfg_addr  = 4'(a);
      cfg_wdata = (a == 5) ? 48'($urandom_range(15)) : 48'({$urandom(), $urandom()});
      cyc(1);
    end
    cfg_valid = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_ad48_irq_ctrl.md
CPU_AD48_IRQ_CTRL -- requirements
Module: cpu_ad48_irq_ctrl

Interface
REQ-001 Parameter SRC_LINES, default 8, number of interrupt sources (legal range 1..16).
REQ-002 Parameter IRQ_LINES, default 4, number of priority-level lines driven into the cpu_ad48 irq input (legal range 2..4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 src  input  SRC_LINES  raw interrupt sources, asynchronous to clk.
REQ-006 cfg_valid  input  1  register access request.
REQ-007 cfg_write  input  1  1 = write, 0 = read.
REQ-008 cfg_addr  input  4  register index.
REQ-009 cfg_wdata  input  48  write data.
REQ-010 cfg_ready  output  1  request accepted; constant 1 out of reset.
REQ-011 cfg_rvalid  output  1  read data valid.
REQ-012 cfg_rdata  output  48  read data.
REQ-013 irq  output  IRQ_LINES  registered per-priority request lines to the CPU.

Function
REQ-014 Registers: 0 PENDING (read; write-1-to-clear, edge sources only), 1 ENABLE (RW), 2 MODE (RW; 1 = edge, 0 = level), 3 PRIO (RW; 2 bits per source, source i at bits [2i+1:2i]), 4 CLAIM (read, side effect), 5 COMPLETE (write); all other addresses read 0, writes ignored.
REQ-015 Bits at or above SRC_LINES (2*SRC_LINES for PRIO) read 0 and ignore writes.
REQ-016 Read latency: cfg_rvalid pulses exactly one cycle after an accepted read; cfg_rdata is 0 whenever cfg_rvalid is 0.
REQ-017 Edge source: pending sets on a 0->1 transition of the sampled source; it clears on a W1C write or a claim.
REQ-018 Level source: pending equals the sampled source level, masked while the source is in service.
REQ-019 Eligible source: pending & enable & ~in_service.
REQ-020 Effective priority: the PRIO field, clamped to IRQ_LINES-1.
REQ-021 irq[k] is registered high when any eligible source has effective priority k.
REQ-022 CLAIM read returns id+1 of the eligible source with the highest effective priority (ties: lowest index), or 0 if none is eligible.
REQ-023 A CLAIM read returning a nonzero value sets that source's in_service bit and clears its pending bit (edge mode), both effective on the same edge as cfg_rvalid.
REQ-024 A COMPLETE write clears in_service[cfg_wdata[3:0]]; a source id >= SRC_LINES, or one not in service, is ignored.
REQ-025 Simultaneous events:
- A new edge in the same cycle as its W1C or claim sets pending (set wins).
- A COMPLETE and a new edge on the same source in one cycle both take effect.
REQ-026 A MODE change clears that source's pending bit.
REQ-027 Latency: a sampled rising edge reaches irq on the 2nd clk edge without synchronizer, on the 4th with it (REQ-031).

Reset
REQ-028 While resetn is low, immediately and asynchronously: PENDING, ENABLE, MODE, PRIO, in_service, sampling flops, irq, cfg_rvalid and cfg_rdata = 0.
REQ-029 Reset asserted mid-claim discards the claim; no in_service bit survives.
REQ-030 cfg_ready = 1 from the first edge after resetn deasserts.

Configuration
REQ-031 With CPU_AD48_IRQ_SYNC_EN defined:
- Each src bit passes through a two-flop synchronizer before edge/level sampling.
- Edge-to-irq latency is 4 cycles.
REQ-032 Without CPU_AD48_IRQ_SYNC_EN:
- src is sampled directly; one history flop provides edge detection.
- Edge-to-irq latency is 2 cycles.
- Sources must be synchronous to clk.

Verification
REQ-033 Reset, ENABLE=0x01, MODE=0x01, PRIO=0 -> pulse src[0] -> irq=4'b0001 after 4 cycles (sync) / 2 (no sync); CLAIM reads 1; irq=0 next cycle; PENDING=0.
REQ-034 Sources 2 and 5 enabled, PRIO[2]=1, PRIO[5]=3, both edges together -> irq=4'b1010; first CLAIM=6, second CLAIM=3, third CLAIM=0.
REQ-035 Level source 3 held high, claimed -> irq drops; COMPLETE 3 while still high -> irq reasserts 1 cycle later; COMPLETE 9 is ignored.
REQ-036 Edge on source 1 in the same cycle as W1C PENDING=0x02 -> PENDING reads 0x02.
REQ-037 resetn pulsed low mid-operation with pending and in_service set -> all registers read 0 and irq=0 immediately.
